// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared definitions for the systolic matrix-multiplication
//               array: default widths, operand mode encodings and helpers
//               that build saturation limits for an arbitrary width.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ACC_WIDTH  = 40;

    // Widest value the limit helpers can describe; callers slice the
    // low ACC_WIDTH bits out of the returned vector.
    localparam int LIMIT_WIDTH = 128;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Largest two's-complement value of the given width: 0111...1
    function automatic logic [LIMIT_WIDTH-1:0] signed_max(input int width);
        logic [LIMIT_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < LIMIT_WIDTH; i++) begin
            if (i < width - 1) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Most negative two's-complement value of the given width: 1000...0
    function automatic logic [LIMIT_WIDTH-1:0] signed_min(input int width);
        logic [LIMIT_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < LIMIT_WIDTH; i++) begin
            if (i == width - 1) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Largest unsigned value of the given width: 1111...1
    function automatic logic [LIMIT_WIDTH-1:0] unsigned_max(input int width);
        logic [LIMIT_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < LIMIT_WIDTH; i++) begin
            if (i < width) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_accum_add.sv
`default_nettype none
// ============================================================================
// Module      : sat_accum_add
// Description : Combinational accumulator adder with signed/unsigned overflow
//               detection and optional clamping to the representable range.
// Ports       : acc, product  - addends (ACC_WIDTH)
//               sign_mode     - 1 = two's complement, 0 = unsigned
//               sat_en        - 1 = clamp on overflow, 0 = wrap
//               sum           - result (ACC_WIDTH)
//               overflow      - addition overflowed in the selected mode
// Revision    : 1.0 - initial release
// ============================================================================
module sat_accum_add
    import systolic_pkg::*;
#(
    parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [ACC_WIDTH-1:0] product,
    input  logic                 sign_mode,
    input  logic                 sat_en,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 overflow
);

    localparam logic [LIMIT_WIDTH-1:0] c_smax_full = signed_max(ACC_WIDTH);
    localparam logic [LIMIT_WIDTH-1:0] c_smin_full = signed_min(ACC_WIDTH);
    localparam logic [LIMIT_WIDTH-1:0] c_umax_full = unsigned_max(ACC_WIDTH);
    localparam logic [ACC_WIDTH-1:0]   c_smax      = c_smax_full[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0]   c_smin      = c_smin_full[ACC_WIDTH-1:0];
    localparam logic [ACC_WIDTH-1:0]   c_umax      = c_umax_full[ACC_WIDTH-1:0];

    logic [ACC_WIDTH:0] w_raw;
    logic               w_signed_ovf;
    logic               w_unsigned_ovf;

    // One extra bit captures the unsigned carry out.
    assign w_raw = {1'b0, acc} + {1'b0, product};

    assign w_signed_ovf   = (acc[ACC_WIDTH-1] == product[ACC_WIDTH-1]) &&
                            (w_raw[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    assign w_unsigned_ovf = w_raw[ACC_WIDTH];

    always_comb begin
        overflow = (sign_mode == MODE_SIGNED) ? w_signed_ovf : w_unsigned_ovf;
        sum      = w_raw[ACC_WIDTH-1:0];
        if (overflow && sat_en) begin
            if (sign_mode == MODE_SIGNED) begin
                // Signed overflow only happens with equal-sign addends, so the
                // accumulator's sign tells which rail was crossed.
                sum = acc[ACC_WIDTH-1] ? c_smin : c_smax;
            end else begin
                sum = c_umax;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_mac_pe.sv
`default_nettype none
// ============================================================================
// Module      : systolic_mac_pe
// Description : Systolic-array processing element. Multiplies the left and up
//               operands, accumulates into a wide (optionally saturating)
//               accumulator and forwards both operands right/down.
// Ports       : clk_i, rst_i (sync, active-high), start_i (new product)
//               valid_i, signed_i, sat_en_i, left_operand_i, up_operand_i
//               right_operand_o, down_operand_o, valid_o (forwarded, 1 cycle)
//               res_o (accumulator), overflow_o (sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_mac_pe
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
    parameter int MUL_PIPE   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  valid_i,
    input  logic                  signed_i,
    input  logic                  sat_en_i,
    input  logic [DATA_WIDTH-1:0] left_operand_i,
    input  logic [DATA_WIDTH-1:0] up_operand_i,
    output logic [DATA_WIDTH-1:0] right_operand_o,
    output logic [DATA_WIDTH-1:0] down_operand_o,
    output logic                  valid_o,
    output logic [ACC_WIDTH-1:0]  res_o,
    output logic                  overflow_o
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    if (ACC_WIDTH < PROD_WIDTH) begin : g_param_check
        $error("systolic_mac_pe: ACC_WIDTH must be at least 2*DATA_WIDTH");
    end

    logic signed [PROD_WIDTH-1:0] w_prod_s;
    logic        [PROD_WIDTH-1:0] w_prod_u;
    logic signed [ACC_WIDTH-1:0]  w_ext_s;
    logic        [ACC_WIDTH-1:0]  w_ext_u;
    logic        [ACC_WIDTH-1:0]  w_prod_ext;

    logic                 w_add_valid;
    logic                 w_add_sign;
    logic                 w_add_sat;
    logic [ACC_WIDTH-1:0] w_add_prod;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_sum_ovf;

    logic [ACC_WIDTH-1:0]  r_acc;
    logic                  r_ovf;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_right;
    logic [DATA_WIDTH-1:0] r_down;

    // Operands widened to the product width before multiplying so the full
    // product is kept; the signed path sign-extends, the unsigned one zero-extends.
    assign w_prod_s = PROD_WIDTH'($signed(left_operand_i)) * PROD_WIDTH'($signed(up_operand_i));
    assign w_prod_u = PROD_WIDTH'(left_operand_i) * PROD_WIDTH'(up_operand_i);
    assign w_ext_s  = ACC_WIDTH'(w_prod_s);
    assign w_ext_u  = ACC_WIDTH'(w_prod_u);
    assign w_prod_ext = (signed_i == MODE_SIGNED) ? w_ext_s : w_ext_u;

    if (MUL_PIPE != 0) begin : g_mul_pipe
        logic                 r_stage_valid;
        logic                 r_stage_sign;
        logic                 r_stage_sat;
        logic [ACC_WIDTH-1:0] r_stage_prod;

        // Mode bits ride along with the product so a later mode change
        // cannot alter a product already in this stage.
        always_ff @(posedge clk_i) begin
            if (rst_i || start_i) begin
                r_stage_valid <= 1'b0;
                r_stage_sign  <= 1'b0;
                r_stage_sat   <= 1'b0;
                r_stage_prod  <= '0;
            end else begin
                r_stage_valid <= valid_i;
                if (valid_i) begin
                    r_stage_sign <= signed_i;
                    r_stage_sat  <= sat_en_i;
                    r_stage_prod <= w_prod_ext;
                end
            end
        end

        assign w_add_valid = r_stage_valid;
        assign w_add_sign  = r_stage_sign;
        assign w_add_sat   = r_stage_sat;
        assign w_add_prod  = r_stage_prod;
    end else begin : g_mul_comb
        assign w_add_valid = valid_i;
        assign w_add_sign  = signed_i;
        assign w_add_sat   = sat_en_i;
        assign w_add_prod  = w_prod_ext;
    end

    sat_accum_add #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_sat_accum_add (
        .acc       (r_acc),
        .product   (w_add_prod),
        .sign_mode (w_add_sign),
        .sat_en    (w_add_sat),
        .sum       (w_sum),
        .overflow  (w_sum_ovf)
    );

    // start_i outranks any product arriving at the adder this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || start_i) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (w_add_valid) begin
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_sum_ovf;
        end
    end

    // Operands are only captured with valid_i so neighbours see stable data
    // across bubbles; start_i drops operands presented with it.
    always_ff @(posedge clk_i) begin
        if (rst_i || start_i) begin
            r_valid <= 1'b0;
            r_right <= '0;
            r_down  <= '0;
        end else begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_right <= left_operand_i;
                r_down  <= up_operand_i;
            end
        end
    end

    assign right_operand_o = r_right;
    assign down_operand_o  = r_down;
    assign valid_o         = r_valid;
    assign res_o           = r_acc;
    assign overflow_o      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_systolic_mac_pe.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_mac_pe
// Description : Self-checking bench for systolic_mac_pe. Two instances
//               (MUL_PIPE = 0 and 1) share the same stimulus and are compared
//               every cycle against an integer-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_mac_pe;

    localparam int DW = 8;
    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, valid, sgn, sat;
    logic [DW-1:0] l_op, u_op;

    logic [DW-1:0] right0, down0, right1, down1;
    logic          valid0, valid1, ovf0, ovf1;
    logic [AW-1:0] res0, res1;

    systolic_mac_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MUL_PIPE(0)) u_dut_p0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid),
        .signed_i(sgn), .sat_en_i(sat),
        .left_operand_i(l_op), .up_operand_i(u_op),
        .right_operand_o(right0), .down_operand_o(down0), .valid_o(valid0),
        .res_o(res0), .overflow_o(ovf0)
    );

    systolic_mac_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MUL_PIPE(1)) u_dut_p1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .valid_i(valid),
        .signed_i(sgn), .sat_en_i(sat),
        .left_operand_i(l_op), .up_operand_i(u_op),
        .right_operand_o(right1), .down_operand_o(down1), .valid_o(valid1),
        .res_o(res1), .overflow_o(ovf1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (plain integer arithmetic) ----------
    logic [AW-1:0] m_acc0 = '0, m_acc1 = '0;
    logic          m_ovf0 = 1'b0, m_ovf1 = 1'b0;
    logic          m_pv = 1'b0, m_ps = 1'b0, m_psat = 1'b0;
    longint        m_pprod = 0;
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_right = '0, m_down = '0;

    function automatic longint prod_val(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
        if (s) return longint'($signed(a)) * longint'($signed(b));
        return longint'(a) * longint'(b);
    endfunction

    function automatic logic [AW-1:0] acc_add(input logic [AW-1:0] acc, input longint p,
                                              input logic s, input logic sa, output logic o);
        longint a, total, lo, hi, r;
        a     = s ? longint'($signed(acc)) : longint'(acc);
        total = a + p;
        lo    = s ? -(longint'(1) << (AW - 1)) : 0;
        hi    = s ? (longint'(1) << (AW - 1)) - 1 : (longint'(1) << AW) - 1;
        o     = 1'b0;
        r     = total;
        if (total > hi) begin
            o = 1'b1;
            r = sa ? hi : total - (longint'(1) << AW);
        end else if (total < lo) begin
            o = 1'b1;
            r = sa ? lo : total + (longint'(1) << AW);
        end
        return r[AW-1:0];
    endfunction

    task automatic model_step();
        longint p;
        logic   o;
        if (rst || start) begin
            m_acc0 = '0; m_acc1 = '0; m_ovf0 = 1'b0; m_ovf1 = 1'b0;
            m_pv = 1'b0; m_valid = 1'b0; m_right = '0; m_down = '0;
        end else begin
            if (m_pv) begin
                m_acc1 = acc_add(m_acc1, m_pprod, m_ps, m_psat, o);
                m_ovf1 = m_ovf1 | o;
            end
            m_pv = valid;
            if (valid) begin
                p       = prod_val(l_op, u_op, sgn);
                m_pprod = p;
                m_ps    = sgn;
                m_psat  = sat;
                m_acc0  = acc_add(m_acc0, p, sgn, sat, o);
                m_ovf0  = m_ovf0 | o;
                m_right = l_op;
                m_down  = u_op;
            end
            m_valid = valid;
        end
    endtask

    task automatic compare_all();
        check("res_p0",   64'(res0),   64'(m_acc0));
        check("ovf_p0",   64'(ovf0),   64'(m_ovf0));
        check("valid_p0", 64'(valid0), 64'(m_valid));
        check("right_p0", 64'(right0), 64'(m_right));
        check("down_p0",  64'(down0),  64'(m_down));
        check("res_p1",   64'(res1),   64'(m_acc1));
        check("ovf_p1",   64'(ovf1),   64'(m_ovf1));
        check("valid_p1", 64'(valid1), 64'(m_valid));
        check("right_p1", 64'(right1), 64'(m_right));
        check("down_p1",  64'(down1),  64'(m_down));
    endtask

    // One clock: inputs already applied, model advances at the edge, outputs
    // are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic drive(input logic r, input logic st, input logic v, input logic s,
                         input logic sa, input int a, input int b);
        rst = r; start = st; valid = v; sgn = s; sat = sa;
        l_op = a[DW-1:0];
        u_op = b[DW-1:0];
        tick();
    endtask

    task automatic mac(input logic s, input logic sa, input int a, input int b);
        drive(1'b0, 1'b0, 1'b1, s, sa, a, b);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    endtask

    task automatic do_start();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    function automatic int rand_op();
        case ($urandom_range(0, 5))
            0:       return 127;
            1:       return -128;
            2:       return 255;
            3:       return 1;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        logic cur_s, cur_sat;
        rst = 1'b1; start = 1'b0; valid = 1'b0; sgn = 1'b0; sat = 1'b0;
        l_op = '0; u_op = '0;
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check("reset_res", 64'(res1), 64'd0);

        // Signed MAC: 12, -18, -32
        do_start();
        mac(1, 0, 3, 4);
        mac(1, 0, -5, 6);
        mac(1, 0, 7, -2);
        idle();
        check("plan_signed_res", 64'(res1), 64'd65504);   // -32
        check("plan_signed_ovf", 64'(ovf1), 64'd0);

        // Unsigned: 65025, 65026, then wraps to 0 with overflow
        do_start();
        mac(0, 0, 255, 255);
        mac(0, 0, 1, 1);
        mac(0, 0, 255, 2);
        idle();
        check("plan_unsigned_res", 64'(res1), 64'd0);
        check("plan_unsigned_ovf", 64'(ovf1), 64'd1);

        // Signed saturation clamps at 32767 and the flag sticks
        do_start();
        repeat (4) mac(1, 1, 127, 127);
        idle();
        check("plan_sat_res", 64'(res1), 64'd32767);
        check("plan_sat_ovf", 64'(ovf1), 64'd1);

        // Same sequence wrapping: third step gives -17149
        do_start();
        repeat (3) mac(1, 0, 127, 127);
        idle();
        check("plan_wrap_res", 64'(res1), 64'd48387);     // -17149

        // Forwarding across a bubble
        do_start();
        mac(1, 0, 9, -1);
        idle();
        check("plan_fwd_hold_right", 64'(right1), 64'd9);
        check("plan_fwd_hold_down",  64'(down1),  64'd255);
        mac(1, 0, 2, 2);
        idle();
        check("plan_fwd_res", 64'(res1), 64'd65531);      // -5

        // start_i colliding with an in-flight product and a new valid
        do_start();
        mac(1, 0, 10, 10);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1);
        check("plan_collide_res",   64'(res1),   64'd0);
        check("plan_collide_valid", 64'(valid1), 64'd0);
        idle();
        check("plan_collide_res2",  64'(res1),   64'd0);

        // Reset mid-run
        repeat (3) mac(1, 0, 5, 5);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        check("plan_rst_res",   64'(res1),   64'd0);
        check("plan_rst_right", 64'(right1), 64'd0);
        mac(1, 0, 2, 3);
        idle();
        check("plan_rst_next_res", 64'(res1), 64'd6);

        // Randomized traffic
        cur_s = 1'b1; cur_sat = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic r, st, v;
            r  = ($urandom_range(0, 99) < 2);
            st = ($urandom_range(0, 99) < 5);
            v  = ($urandom_range(0, 99) < 75);
            if ($urandom_range(0, 9) == 0) cur_s   = ~cur_s;
            if ($urandom_range(0, 9) == 0) cur_sat = ~cur_sat;
            drive(r, st, v, cur_s, cur_sat, rand_op(), rand_op());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
